// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave byte controller: address match, byte receive and transmit.
// Single clock domain, oversampled SCL/SDA, open-drain SDA enable.
`timescale 1ns/1ps
module i2c_slave_byte_ctrl #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Scl_i,
   input  logic       Sda_i,
   output logic       Sda_oe,
   input  logic       Rx_ready,
   output logic [7:0] Rx_data,
   output logic       Rx_valid,
   input  logic [7:0] Tx_data,
   output logic       Tx_req,
   output logic       Tx_nack,
   output logic       Rw,
   output logic       Addr_match,
   output logic       Busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_BYTE,
      RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
   } state_t;

   logic [2:0] scl_q, sda_q;
   logic [1:0] settle_q;
   logic       armed;
   logic       scl_s, scl_d, sda_s, sda_d;
   logic       start_det, stop_det, scl_rise, scl_fall;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic       done_q, done_d;
   logic       oe_q, oe_d;
   logic [7:0] rxd_q, rxd_d;
   logic       rxv_q, rxv_d;
   logic       txr_q, txr_d;
   logic       txn_q, txn_d;
   logic       rw_q, rw_d;
   logic       am_q, am_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;

   // Two-flop synchronizers plus one delayed copy for edge detection
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         scl_q    <= 3'b111;
         sda_q    <= 3'b111;
         settle_q <= 2'd0;
      end else begin
         scl_q <= {scl_q[1:0], Scl_i};
         sda_q <= {sda_q[1:0], Sda_i};
         if (settle_q != 2'd3)
            settle_q <= settle_q + 2'd1;
      end
   end

   // Edges seen while the pipeline still holds reset ones are not real bus events
   assign armed     = (settle_q == 2'd3);
   assign scl_s     = scl_q[1];
   assign scl_d     = scl_q[2];
   assign sda_s     = sda_q[1];
   assign sda_d     = sda_q[2];
   assign start_det = armed & scl_s & sda_d & ~sda_s;
   assign stop_det  = armed & scl_s & ~sda_d & sda_s;
   assign scl_rise  = armed & scl_s & ~scl_d;
   assign scl_fall  = armed & ~scl_s & scl_d;

   // FSM and datapath state register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         sh_q    <= 8'h00;
         done_q  <= 1'b0;
         oe_q    <= 1'b0;
         rxd_q   <= 8'h00;
         rxv_q   <= 1'b0;
         txr_q   <= 1'b0;
         txn_q   <= 1'b0;
         rw_q    <= 1'b0;
         am_q    <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         done_q  <= done_d;
         oe_q    <= oe_d;
         rxd_q   <= rxd_d;
         rxv_q   <= rxv_d;
         txr_q   <= txr_d;
         txn_q   <= txn_d;
         rw_q    <= rw_d;
         am_q    <= am_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state and output logic; START/STOP override any SCL edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      done_d  = done_q;
      oe_d    = oe_q;
      rxd_d   = rxd_q;
      rxv_d   = 1'b0;
      txr_d   = 1'b0;
      txn_d   = 1'b0;
      rw_d    = rw_q;
      am_d    = am_q;
      busy_d  = busy_q;
      ack_d   = ack_q;
      if (start_det) begin
         state_d = ADDR;
         cnt_d   = 3'd0;
         done_d  = 1'b0;
         oe_d    = 1'b0;
         am_d    = 1'b0;
         busy_d  = 1'b1;
      end else if (stop_det) begin
         state_d = IDLE;
         done_d  = 1'b0;
         oe_d    = 1'b0;
         am_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               oe_d = 1'b0;
            end
            ADDR: begin
               if (scl_rise) begin
                  sh_d  = {sh_q[6:0], sda_s};
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7)
                     done_d = 1'b1;
               end else if (scl_fall && done_q) begin
                  done_d = 1'b0;
                  cnt_d  = 3'd0;
                  if (sh_q[7:1] == SLAVE_ADDR) begin
                     oe_d    = 1'b1;
                     rw_d    = sh_q[0];
                     am_d    = 1'b1;
                     state_d = ADDR_ACK;
                  end else begin
                     oe_d    = 1'b0;
                     state_d = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 3'd0;
                  if (!rw_q) begin
                     oe_d    = 1'b0;
                     state_d = RX_BYTE;
                  end else begin
                     txr_d   = 1'b1;
                     sh_d    = Tx_data;
                     oe_d    = ~Tx_data[7];
                     state_d = TX_BYTE;
                  end
               end
            end
            RX_BYTE: begin
               if (scl_rise) begin
                  sh_d  = {sh_q[6:0], sda_s};
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     done_d = 1'b1;
                     ack_d  = Rx_ready;
                     if (Rx_ready) begin
                        rxd_d = {sh_q[6:0], sda_s};
                        rxv_d = 1'b1;
                     end
                  end
               end else if (scl_fall && done_q) begin
                  done_d  = 1'b0;
                  oe_d    = ack_q;
                  state_d = RX_ACK;
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  oe_d  = 1'b0;
                  cnt_d = 3'd0;
                  if (ack_q)
                     state_d = RX_BYTE;
                  else
                     state_d = WAIT_STOP;
               end
            end
            TX_BYTE: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     oe_d    = 1'b0;
                     cnt_d   = 3'd0;
                     state_d = TX_ACK;
                  end else begin
                     sh_d  = {sh_q[6:0], 1'b0};
                     oe_d  = ~sh_q[6];
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     txn_d   = 1'b1;
                     state_d = WAIT_STOP;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if (scl_fall && done_q) begin
                  done_d  = 1'b0;
                  txr_d   = 1'b1;
                  sh_d    = Tx_data;
                  oe_d    = ~Tx_data[7];
                  cnt_d   = 3'd0;
                  state_d = TX_BYTE;
               end
            end
            WAIT_STOP: begin
               oe_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   assign Sda_oe     = oe_q;
   assign Rx_data    = rxd_q;
   assign Rx_valid   = rxv_q;
   assign Tx_req     = txr_q;
   assign Tx_nack    = txn_q;
   assign Rw         = rw_q;
   assign Addr_match = am_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: bit-banged master, vector table,
// and queue scoreboards for received and transmitted bytes.
`timescale 1ns/1ps
module tb_i2c_slave_byte_ctrl;

   localparam int Q = 5;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       scl_m;
   logic       sda_m;
   logic       sda_line;
   logic       Sda_oe;
   logic       Rx_ready;
   logic [7:0] Rx_data;
   logic       Rx_valid;
   logic [7:0] Tx_data;
   logic       Tx_req;
   logic       Tx_nack;
   logic       Rw;
   logic       Addr_match;
   logic       Busy;

   assign sda_line = sda_m & ~Sda_oe;

   i2c_slave_byte_ctrl #(.SLAVE_ADDR(7'h50)) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .Scl_i      (scl_m),
      .Sda_i      (sda_line),
      .Sda_oe     (Sda_oe),
      .Rx_ready   (Rx_ready),
      .Rx_data    (Rx_data),
      .Rx_valid   (Rx_valid),
      .Tx_data    (Tx_data),
      .Tx_req     (Tx_req),
      .Tx_nack    (Tx_nack),
      .Rw         (Rw),
      .Addr_match (Addr_match),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] d;
      logic       rdy;
      int         nb;
      logic       a_ack;
      logic       d_ack;
   } vec_t;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] got_rx[$];
   int         txr_cnt = 0;
   int         txn_cnt = 0;
   int         oe_cnt = 0;
   int         busy_lo = 0;

   // Output monitor
   always @(negedge Clk) begin
      if (Rx_valid) got_rx.push_back(Rx_data);
      if (Tx_req) txr_cnt++;
      if (Tx_nack) txn_cnt++;
      if (Sda_oe) oe_cnt++;
      if (!Busy) busy_lo++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];
   int         rd_ptr = 0;
   logic [7:0] rx_model = 8'h00;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      b = sda_line; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic x;
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(x);
      ack = ~x;
   endtask

   task automatic read_byte(output logic [7:0] b);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         read_bit(x);
         b[i] = x;
      end
   endtask

   task automatic drain_rx();
      logic [7:0] e;
      while (rd_ptr < got_rx.size()) begin
         if (exp_rx.size() == 0) begin
            check("rx_unexpected", {24'h0, got_rx[rd_ptr]}, 32'hFFFF_FFFF);
         end else begin
            e = exp_rx.pop_front();
            check("rx_byte", {24'h0, got_rx[rd_ptr]}, {24'h0, e});
         end
         rd_ptr++;
      end
   endtask

   task automatic tx_compare(input logic [7:0] b);
      logic [7:0] e;
      if (exp_tx.size() == 0) begin
         check("tx_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
      end else begin
         e = exp_tx.pop_front();
         check("tx_byte", {24'h0, b}, {24'h0, e});
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_oe"},   {31'h0, Sda_oe}, 0);
      check({tag, "_rxd"},  {24'h0, Rx_data}, 0);
      check({tag, "_rxv"},  {31'h0, Rx_valid}, 0);
      check({tag, "_txr"},  {31'h0, Tx_req}, 0);
      check({tag, "_txn"},  {31'h0, Tx_nack}, 0);
      check({tag, "_rw"},   {31'h0, Rw}, 0);
      check({tag, "_am"},   {31'h0, Addr_match}, 0);
      check({tag, "_busy"}, {31'h0, Busy}, 0);
   endtask

   vec_t vecs[7];

   initial begin
      logic       ack;
      logic [7:0] b;
      int         oe0, txr0, txn0, bl0;

      vecs[0] = '{8'hA0, 8'hA5, 1'b1, 1, 1'b1, 1'b1};
      vecs[1] = '{8'hA2, 8'h5A, 1'b1, 1, 1'b0, 1'b0};
      vecs[2] = '{8'hA0, 8'h77, 1'b0, 2, 1'b1, 1'b0};
      vecs[3] = '{8'hA0, 8'h00, 1'b1, 1, 1'b1, 1'b1};
      vecs[4] = '{8'hA0, 8'hFF, 1'b1, 2, 1'b1, 1'b1};
      vecs[5] = '{8'h20, 8'h3C, 1'b1, 1, 1'b0, 1'b0};
      vecs[6] = '{8'hAE, 8'h81, 1'b1, 1, 1'b0, 1'b0};

      Rst_n = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      Rx_ready = 1'b1;
      Tx_data = 8'h00;
      tick(4);
      check_reset_vals("reset");
      Rst_n = 1'b1;
      tick(6);

      // Table-driven write frames
      for (int v = 0; v < 7; v++) begin
         Rx_ready = vecs[v].rdy;
         oe0 = oe_cnt;
         txr0 = txr_cnt;
         i2c_start();
         check($sformatf("v%0d_busy", v), {31'h0, Busy}, 1);
         write_byte(vecs[v].addr, ack);
         check($sformatf("v%0d_aack", v), {31'h0, ack},
               {31'h0, vecs[v].a_ack});
         check($sformatf("v%0d_am", v), {31'h0, Addr_match},
               {31'h0, vecs[v].a_ack});
         if (vecs[v].a_ack)
            check($sformatf("v%0d_rw", v), {31'h0, Rw}, 0);
         for (int k = 0; k < vecs[v].nb; k++) begin
            write_byte(vecs[v].d, ack);
            check($sformatf("v%0d_dack%0d", v, k), {31'h0, ack},
                  {31'h0, vecs[v].d_ack});
            if (vecs[v].d_ack) begin
               exp_rx.push_back(vecs[v].d);
               rx_model = vecs[v].d;
            end
         end
         i2c_stop();
         tick(Q);
         check($sformatf("v%0d_busy_off", v), {31'h0, Busy}, 0);
         check($sformatf("v%0d_am_off", v), {31'h0, Addr_match}, 0);
         check($sformatf("v%0d_rxd", v), {24'h0, Rx_data},
               {24'h0, rx_model});
         check($sformatf("v%0d_txr", v), txr_cnt - txr0, 0);
         if (!vecs[v].a_ack)
            check($sformatf("v%0d_oe_quiet", v), oe_cnt - oe0, 0);
         drain_rx();
      end

      // Read with master NACK
      Rx_ready = 1'b1;
      Tx_data = 8'h3C;
      exp_tx.push_back(8'h3C);
      txr0 = txr_cnt;
      txn0 = txn_cnt;
      i2c_start();
      write_byte(8'hA1, ack);
      check("rd_aack", {31'h0, ack}, 1);
      check("rd_rw", {31'h0, Rw}, 1);
      read_byte(b);
      tx_compare(b);
      write_bit(1'b1);
      check("rd_txr", txr_cnt - txr0, 1);
      check("rd_txn", txn_cnt - txn0, 1);
      oe0 = oe_cnt;
      write_byte(8'h00, ack);
      check("rd_wait_stop_oe", oe_cnt - oe0, 0);
      check("rd_wait_busy", {31'h0, Busy}, 1);
      i2c_stop();
      tick(Q);
      check("rd_busy_off", {31'h0, Busy}, 0);

      // Repeated START: write then read two bytes
      txr0 = txr_cnt;
      Tx_data = 8'h5A;
      i2c_start();
      bl0 = busy_lo;
      write_byte(8'hA0, ack);
      check("rs_aack1", {31'h0, ack}, 1);
      write_byte(8'h11, ack);
      check("rs_dack", {31'h0, ack}, 1);
      exp_rx.push_back(8'h11);
      rx_model = 8'h11;
      i2c_start();
      check("rs_busy", {31'h0, Busy}, 1);
      exp_tx.push_back(8'h5A);
      write_byte(8'hA1, ack);
      check("rs_aack2", {31'h0, ack}, 1);
      read_byte(b);
      tx_compare(b);
      Tx_data = 8'hC3;
      exp_tx.push_back(8'hC3);
      write_bit(1'b0);
      read_byte(b);
      tx_compare(b);
      write_bit(1'b1);
      check("rs_busy_held", busy_lo - bl0, 0);
      check("rs_rxd", {24'h0, Rx_data}, 8'h11);
      check("rs_rw", {31'h0, Rw}, 1);
      check("rs_txr", txr_cnt - txr0, 2);
      i2c_stop();
      tick(Q);
      drain_rx();

      // Reset in the middle of a read while SDA is pulled low
      Tx_data = 8'h00;
      i2c_start();
      write_byte(8'hA1, ack);
      for (int i = 0; i < 4; i++) read_bit(ack);
      check("mr_oe_before", {31'h0, Sda_oe}, 1);
      #3;
      Rst_n = 1'b0;
      #1;
      check_reset_vals("mr");
      rx_model = 8'h00;
      tick(3);
      Rst_n = 1'b1;
      tick(6);
      check("mr_idle_busy", {31'h0, Busy}, 0);
      Rx_ready = 1'b1;
      i2c_start();
      check("mr_busy", {31'h0, Busy}, 1);
      write_byte(8'hA0, ack);
      check("mr_aack", {31'h0, ack}, 1);
      write_byte(8'h42, ack);
      check("mr_dack", {31'h0, ack}, 1);
      exp_rx.push_back(8'h42);
      rx_model = 8'h42;
      i2c_stop();
      tick(Q);
      check("mr_rxd", {24'h0, Rx_data}, {24'h0, rx_model});
      drain_rx();

      check("rx_left", exp_rx.size(), 0);
      check("tx_left", exp_tx.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
